// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, port ids
// and the arbitration rule used when both ports request together.
package mem_port_arbiter_pkg;

    localparam int WORD_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // A tie goes to the port that was not served last.
    function automatic logic pick_winner(input logic i_req,
                                         input logic d_req,
                                         input logic last_served);
        logic winner;
        if (i_req && d_req) begin
            winner = ~last_served;
        end else if (d_req) begin
            winner = PORT_D;
        end else begin
            winner = PORT_I;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Two-input word multiplexer used to pick the winning port's command fields.
module mem_port_arbiter_mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory
// port; one transaction in flight, IDLE -> BUSY -> RESP per access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [WORD_WIDTH-1:0] i_addr,
    output logic [WORD_WIDTH-1:0] i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [WORD_WIDTH-1:0] d_addr,
    input  logic [WORD_WIDTH-1:0] d_wdata,
    output logic [WORD_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  m_req,
    output logic                  m_we,
    output logic [WORD_WIDTH-1:0] m_addr,
    output logic [WORD_WIDTH-1:0] m_wdata,
    input  logic [WORD_WIDTH-1:0] m_rdata,
    input  logic                  m_ready,
    output logic                  grant_sel
);

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    load_cmd_s;
    logic                    finish_s;
    logic                    release_s;
    logic                    winner_s;
    logic [WORD_WIDTH-1:0]   addr_sel_s;
    logic [WORD_WIDTH-1:0]   wdata_sel_s;

    logic                    owner_r;
    logic                    last_served_r;
    logic                    grant_sel_r;
    logic                    m_req_r;
    logic                    m_we_r;
    logic [WORD_WIDTH-1:0]   m_addr_r;
    logic [WORD_WIDTH-1:0]   m_wdata_r;
    logic                    i_ack_r;
    logic                    d_ack_r;
    logic [WORD_WIDTH-1:0]   i_rdata_r;
    logic [WORD_WIDTH-1:0]   d_rdata_r;

    assign winner_s = pick_winner(i_req, d_req, last_served_r);

    mem_port_arbiter_mux2 #(.WIDTH(WORD_WIDTH)) u_addr_mux (
        .a   (i_addr),
        .b   (d_addr),
        .sel (winner_s),
        .y   (addr_sel_s)
    );

    // Fetches never write, so the fetch leg of the write-data mux is zero.
    mem_port_arbiter_mux2 #(.WIDTH(WORD_WIDTH)) u_wdata_mux (
        .a   ({WORD_WIDTH{1'b0}}),
        .b   (d_wdata),
        .sel (winner_s),
        .y   (wdata_sel_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and per-phase strobes; requests only sampled in IDLE.
    always_comb begin
        state_next_s = state_r;
        load_cmd_s   = 1'b0;
        finish_s     = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    state_next_s = ST_BUSY;
                    load_cmd_s   = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (m_ready) begin
                    state_next_s = ST_RESP;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
                release_s    = 1'b1;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Command, response and arbitration-history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r       <= PORT_I;
            last_served_r <= PORT_D;
            grant_sel_r   <= PORT_I;
            m_req_r       <= 1'b0;
            m_we_r        <= 1'b0;
            m_addr_r      <= {WORD_WIDTH{1'b0}};
            m_wdata_r     <= {WORD_WIDTH{1'b0}};
            i_ack_r       <= 1'b0;
            d_ack_r       <= 1'b0;
            i_rdata_r     <= {WORD_WIDTH{1'b0}};
            d_rdata_r     <= {WORD_WIDTH{1'b0}};
        end else if (load_cmd_s) begin
            owner_r     <= winner_s;
            grant_sel_r <= winner_s;
            m_req_r     <= 1'b1;
            m_we_r      <= winner_s & d_we;
            m_addr_r    <= addr_sel_s;
            m_wdata_r   <= wdata_sel_s;
        end else if (finish_s) begin
            m_req_r <= 1'b0;
            if (owner_r == PORT_D) begin
                d_ack_r   <= 1'b1;
                d_rdata_r <= m_rdata;
            end else begin
                i_ack_r   <= 1'b1;
                i_rdata_r <= m_rdata;
            end
        end else if (release_s) begin
            i_ack_r       <= 1'b0;
            d_ack_r       <= 1'b0;
            last_served_r <= owner_r;
        end else begin
            m_req_r <= m_req_r;
        end
    end

    assign m_req     = m_req_r;
    assign m_we      = m_we_r;
    assign m_addr    = m_addr_r;
    assign m_wdata   = m_wdata_r;
    assign i_ack     = i_ack_r;
    assign d_ack     = d_ack_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign grant_sel = grant_sel_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a
// transaction-level model of arbitration, latency and command contents.
module tb_mem_port_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_req = 1'b0;
    logic [W-1:0] i_addr = '0;
    logic [W-1:0] i_rdata;
    logic         i_ack;
    logic         d_req = 1'b0;
    logic         d_we = 1'b0;
    logic [W-1:0] d_addr = '0;
    logic [W-1:0] d_wdata = '0;
    logic [W-1:0] d_rdata;
    logic         d_ack;
    logic         m_req;
    logic         m_we;
    logic [W-1:0] m_addr;
    logic [W-1:0] m_wdata;
    logic [W-1:0] m_rdata = '0;
    logic         m_ready = 1'b0;
    logic         grant_sel;

    int   tests_run = 0;
    int   fails = 0;
    logic model_last;
    logic model_gsel;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .grant_sel(grant_sel)
    );

    typedef struct {
        int           grant_cyc;
        int           ack_cyc;
        int           mreq_cycles;
        logic [W-1:0] addr;
        logic         we;
        logic [W-1:0] wdata;
        logic         gsel;
        logic         gsel_resp;
        logic         stable;
        int           i_acks;
        int           d_acks;
        logic         both;
        logic [W-1:0] rdata;
        logic [W-1:0] rdata_hold;
        logic         timeout;
    } obs_t;

    // Arbitration rule: a lone requester wins; a tie goes to the port not served last.
    function automatic logic exp_winner(input logic ir, input logic dr, input logic last);
        if (ir && dr) return !last;
        return dr;
    endfunction

    // Plays memory and requester for one transaction and records what the DUT did.
    task automatic observe_txn(input int waits, input logic [W-1:0] rd,
                               input logic drop_i, input logic drop_d, output obs_t o);
        int busy_cnt = 0;
        o.grant_cyc = -1; o.ack_cyc = -1; o.mreq_cycles = 0;
        o.addr = '0; o.we = 1'b0; o.wdata = '0; o.gsel = 1'b0; o.gsel_resp = 1'b0;
        o.stable = 1'b1; o.i_acks = 0; o.d_acks = 0; o.both = 1'b0;
        o.rdata = '0; o.rdata_hold = '0; o.timeout = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            if (i_ack) o.i_acks++;
            if (d_ack) o.d_acks++;
            if (i_ack && d_ack) o.both = 1'b1;
            if (o.ack_cyc >= 0) begin
                o.rdata_hold = (o.d_acks > 0) ? d_rdata : i_rdata;
                o.timeout = 1'b0;
                m_ready = 1'($urandom);
                return;
            end
            if (i_ack || d_ack) begin
                o.ack_cyc = cyc;
                o.rdata = d_ack ? d_rdata : i_rdata;
                o.gsel_resp = grant_sel;
                if (i_ack) i_req = 1'b0;
                if (d_ack) d_req = 1'b0;
            end
            if (m_req) begin
                if (o.grant_cyc < 0) begin
                    o.grant_cyc = cyc;
                    o.addr = m_addr; o.we = m_we; o.wdata = m_wdata; o.gsel = grant_sel;
                    if (drop_i) i_req = 1'b0;
                    if (drop_d) d_req = 1'b0;
                end else if ({m_addr, m_we, m_wdata, grant_sel} !== {o.addr, o.we, o.wdata, o.gsel}) begin
                    o.stable = 1'b0;
                end
                o.mreq_cycles++;
                m_ready = (busy_cnt == waits);
                m_rdata = m_ready ? rd : $urandom;
                busy_cnt++;
            end else begin
                m_ready = 1'($urandom);
                m_rdata = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        model_last = 1'b1;
        model_gsel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; m_ready = 1'b1;
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; m_rdata = $urandom;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({m_req, m_we, i_ack, d_ack, grant_sel} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl got m_req/m_we/i_ack/d_ack/gsel=%b required 00000",
                     {m_req, m_we, i_ack, d_ack, grant_sel});
        end
        tests_run++;
        if ({m_addr, m_wdata, i_rdata, d_rdata} !== {4*W{1'b0}}) begin
            fails++;
            $display("FAIL reset_data got addr=%h wdata=%h ird=%h drd=%h required all 0",
                     m_addr, m_wdata, i_rdata, d_rdata);
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
        rst = 1'b0;
        model_last = 1'b1;
        model_gsel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (m_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle got m_req=%b required 0", m_req);
        end
    endtask

    task automatic test_single_fetch();
        obs_t o;
        i_req = 1'b1; i_addr = 32'h0000_0040; d_req = 1'b0;
        observe_txn(0, 32'h2402_0005, 1'b0, 1'b0, o);
        tests_run++;
        if (o.grant_cyc !== 1 || o.mreq_cycles !== 1 || o.ack_cyc !== 2) begin
            fails++;
            $display("FAIL fetch_timing got grant=%0d mreq=%0d ack=%0d required 1 1 2",
                     o.grant_cyc, o.mreq_cycles, o.ack_cyc);
        end
        tests_run++;
        if ({o.we, o.addr} !== {1'b0, 32'h0000_0040}) begin
            fails++;
            $display("FAIL fetch_cmd got we=%b addr=%h required we=0 addr=00000040", o.we, o.addr);
        end
        tests_run++;
        if (o.i_acks !== 1 || o.d_acks !== 0 || o.rdata !== 32'h2402_0005 || o.rdata_hold !== 32'h2402_0005) begin
            fails++;
            $display("FAIL fetch_resp got iack=%0d dack=%0d rdata=%h hold=%h required 1 0 24020005 24020005",
                     o.i_acks, o.d_acks, o.rdata, o.rdata_hold);
        end
        model_last = 1'b0;
        model_gsel = 1'b0;
    endtask

    task automatic test_data_write();
        obs_t o;
        logic [W-1:0] rd;
        rd = $urandom;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF;
        observe_txn(3, rd, 1'b0, 1'b0, o);
        tests_run++;
        if (o.mreq_cycles !== 4 || o.stable !== 1'b1 || o.ack_cyc !== 5) begin
            fails++;
            $display("FAIL write_busy got mreq=%0d stable=%b ack=%0d required 4 1 5",
                     o.mreq_cycles, o.stable, o.ack_cyc);
        end
        tests_run++;
        if ({o.we, o.addr, o.wdata} !== {1'b1, 32'h0000_1000, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL write_cmd got we=%b addr=%h wdata=%h required 1 00001000 deadbeef",
                     o.we, o.addr, o.wdata);
        end
        tests_run++;
        if (o.d_acks !== 1 || o.i_acks !== 0 || o.gsel !== 1'b1 || o.gsel_resp !== 1'b1) begin
            fails++;
            $display("FAIL write_ack got dack=%0d iack=%0d gsel=%b/%b required 1 0 1/1",
                     o.d_acks, o.i_acks, o.gsel, o.gsel_resp);
        end
        model_last = 1'b1;
        model_gsel = 1'b1;
    endtask

    task automatic test_tie_alternation();
        obs_t o;
        logic exp;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (!i_req) i_addr = $urandom;
            if (!d_req) begin d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom; end
            i_req = 1'b1; d_req = 1'b1;
            exp = (k % 2 == 1);
            observe_txn(int'($urandom_range(0, 2)), $urandom, 1'b0, 1'b0, o);
            tests_run++;
            if ((exp ? o.d_acks : o.i_acks) !== 1 || (exp ? o.i_acks : o.d_acks) !== 0
                || o.addr !== (exp ? d_addr : i_addr) || o.grant_cyc !== 1) begin
                fails++;
                $display("FAIL tie_%0d got iack=%0d dack=%0d addr=%h grant=%0d required owner=%b",
                         k, o.i_acks, o.d_acks, o.addr, o.grant_cyc, exp);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        model_last = 1'b1;
        model_gsel = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_busy();
        obs_t o;
        int   acks;
        int   mreqs;
        do_reset();
        i_req = 1'b1; i_addr = $urandom;
        observe_txn(0, $urandom, 1'b0, 1'b0, o);
        d_req = 1'b1; d_we = 1'b0; d_addr = $urandom; m_ready = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (m_req !== 1'b1 || grant_sel !== 1'b1) begin
            fails++;
            $display("FAIL rstbusy_grant got m_req=%b gsel=%b required 1 1", m_req, grant_sel);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; d_req = 1'b0;
        tests_run++;
        if ({m_req, d_ack, grant_sel} !== 3'b000) begin
            fails++;
            $display("FAIL rstbusy_drop got m_req/dack/gsel=%b required 000", {m_req, d_ack, grant_sel});
        end
        acks = 0; mreqs = 0;
        for (int c = 0; c < 4; c++) begin
            m_ready = 1'($urandom);
            @(posedge clk); #1;
            acks += int'(d_ack) + int'(i_ack);
            mreqs += int'(m_req);
        end
        tests_run++;
        if (acks !== 0 || mreqs !== 0) begin
            fails++;
            $display("FAIL rstbusy_quiet got acks=%0d mreq_cycles=%0d required 0 0", acks, mreqs);
        end
        i_req = 1'b1; d_req = 1'b1; i_addr = $urandom; d_addr = $urandom;
        observe_txn(1, $urandom, 1'b0, 1'b0, o);
        tests_run++;
        if (o.i_acks !== 1 || o.d_acks !== 0) begin
            fails++;
            $display("FAIL rstbusy_tie got iack=%0d dack=%0d required fetch first (1 0)", o.i_acks, o.d_acks);
        end
        observe_txn(0, $urandom, 1'b0, 1'b0, o);
        model_last = 1'b1;
        model_gsel = 1'b1;
    endtask

    task automatic test_dropped();
        obs_t o;
        logic [W-1:0] rd;
        rd = $urandom;
        i_req = 1'b1; i_addr = $urandom; d_req = 1'b0;
        observe_txn(2, rd, 1'b1, 1'b0, o);
        tests_run++;
        if (o.i_acks !== 1 || o.d_acks !== 0 || o.ack_cyc !== 4 || o.rdata !== rd) begin
            fails++;
            $display("FAIL dropped got iack=%0d dack=%0d ack=%0d rdata=%h required 1 0 4 %h",
                     o.i_acks, o.d_acks, o.ack_cyc, o.rdata, rd);
        end
        model_last = 1'b0;
        model_gsel = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic w;
        logic exp_we;
        logic [W-1:0] exp_addr, exp_wdata, rd;
        int waits;
        for (int n = 0; n < 40; n++) begin
            if (!i_req) begin i_req = 1'($urandom); i_addr = $urandom; end
            if (!d_req) begin d_req = 1'($urandom); d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom; end
            if (!i_req && !d_req) begin
                for (int c = 0; c < 3; c++) begin
                    m_ready = 1'($urandom);
                    @(posedge clk); #1;
                    tests_run++;
                    if ({m_req, i_ack, d_ack} !== 3'b000 || grant_sel !== model_gsel) begin
                        fails++;
                        $display("FAIL idle_hold got m_req/iack/dack=%b gsel=%b required 000 %b",
                                 {m_req, i_ack, d_ack}, grant_sel, model_gsel);
                    end
                end
                continue;
            end
            w = exp_winner(i_req, d_req, model_last);
            exp_addr  = w ? d_addr : i_addr;
            exp_we    = w ? d_we : 1'b0;
            exp_wdata = w ? d_wdata : '0;
            waits = int'($urandom_range(0, 4));
            rd = $urandom;
            observe_txn(waits, rd, ($urandom_range(0, 4) == 0) && !w,
                        ($urandom_range(0, 4) == 0) && w, o);
            tests_run++;
            if (o.timeout || o.grant_cyc !== 1 || o.ack_cyc !== waits + 2 || o.mreq_cycles !== waits + 1) begin
                fails++;
                $display("FAIL rand_timing n=%0d got to=%b grant=%0d ack=%0d mreq=%0d required 0 1 %0d %0d",
                         n, o.timeout, o.grant_cyc, o.ack_cyc, o.mreq_cycles, waits + 2, waits + 1);
            end
            tests_run++;
            if ({o.we, o.addr, o.wdata, o.stable} !== {exp_we, exp_addr, exp_wdata, 1'b1}) begin
                fails++;
                $display("FAIL rand_cmd n=%0d got we=%b addr=%h wdata=%h stable=%b required %b %h %h 1",
                         n, o.we, o.addr, o.wdata, o.stable, exp_we, exp_addr, exp_wdata);
            end
            tests_run++;
            if ((w ? o.d_acks : o.i_acks) !== 1 || (w ? o.i_acks : o.d_acks) !== 0 || o.both
                || o.gsel !== w || o.gsel_resp !== w) begin
                fails++;
                $display("FAIL rand_ack n=%0d got iack=%0d dack=%0d both=%b gsel=%b/%b required owner=%b",
                         n, o.i_acks, o.d_acks, o.both, o.gsel, o.gsel_resp, w);
            end
            tests_run++;
            if (o.rdata !== rd || o.rdata_hold !== rd) begin
                fails++;
                $display("FAIL rand_rdata n=%0d got %h hold=%h required %h", n, o.rdata, o.rdata_hold, rd);
            end
            model_last = w;
            model_gsel = w;
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_write();
        test_tie_alternation();
        test_reset_mid_busy();
        test_dropped();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default `WORD_WIDTH (32), data and address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_req  in  1  instruction-fetch read request, held until i_ack.
REQ-005 i_addr  in  WORD_WIDTH  fetch address, stable while i_req=1.
REQ-006 i_rdata  out  WORD_WIDTH  fetch read data, valid only when i_ack=1.
REQ-007 i_ack  out  1  one-cycle completion pulse to fetch port.
REQ-008 d_req  in  1  data-port request, held until d_ack.
REQ-009 d_we  in  1  1=write, 0=read; stable while d_req=1.
REQ-010 d_addr  in  WORD_WIDTH  data address, stable while d_req=1.
REQ-011 d_wdata  in  WORD_WIDTH  write data, stable while d_req=1.
REQ-012 d_rdata  out  WORD_WIDTH  data read result, valid only when d_ack=1.
REQ-013 d_ack  out  1  one-cycle completion pulse to data port.
REQ-014 m_req  out  1  shared-memory request, held until m_ready sampled high.
REQ-015 m_we, m_addr, m_wdata  out  1/WORD_WIDTH/WORD_WIDTH  registered shared-memory command.
REQ-016 m_rdata  in  WORD_WIDTH  memory read data, valid when m_ready=1.
REQ-017 m_ready  in  1  memory completion; ignored while m_req=0.
REQ-018 grant_sel  out  1  current owner: 0=fetch, 1=data; drives external port-select mux.

Function
REQ-019 FSM states IDLE, BUSY, RESP; owner register (1 bit) and last_served register (1 bit).
REQ-020 IDLE: if exactly one req high, grant it; if both high, grant the port != last_served; none high -> stay IDLE.
REQ-021 On grant (IDLE edge): latch owner, m_addr/m_we/m_wdata from owner's port (m_we=0 for fetch), set m_req=1, go BUSY.
REQ-022 BUSY: m_req=1 and m_* held constant until edge where m_ready=1; then m_req=0, capture m_rdata, go RESP.
REQ-023 RESP: owner's ack=1 for exactly one cycle with captured rdata; last_served<=owner; go IDLE.
REQ-024 Requests are not sampled in BUSY or RESP; a requester deasserts req in the cycle after its ack.
REQ-025 Minimum latency: req high before edge 0 -> m_req high after edge 0 -> ack high after edge 1 (zero-wait memory: m_ready=1 in first BUSY cycle).
REQ-026 Throughput: at most one transaction per 3 cycles; no back-to-back BUSY without IDLE.
REQ-027 grant_sel equals owner in BUSY and RESP; holds last value in IDLE.
REQ-028 Requester deasserting req during BUSY does not abort; transaction completes and ack still pulses.
REQ-029 Both acks never high in the same cycle; ack of the non-owner is always 0.
REQ-030 i_rdata/d_rdata hold captured value between acks (no requirement on content when ack=0).
REQ-031 No internal timeout; indefinite m_ready=0 holds BUSY.

Reset
REQ-032 rst=1 at edge: state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, rdata regs=0, grant_sel=0, owner=0, last_served=1 (fetch wins first tie).
REQ-033 rst mid-BUSY/RESP: transaction dropped, no ack issued, m_req low after that edge.
REQ-034 rst overrides all other inputs in the same cycle.

Structure
REQ-035 FSM state encoding (2 bits) and port-id constants (PORT_I=0, PORT_D=1) in shared constants.v; WORD_WIDTH from there.
REQ-036 Command selection at grant uses MUX2 instances (sel = grant winner) for address and write data; no other sub-module.

Verification
REQ-037 Single fetch, zero-wait: i_req=1, i_addr=0x0000_0040, m_ready=1, m_rdata=0x2402_0005 -> m_addr=0x40, m_we=0 one cycle; i_ack pulse 2 cycles after request, i_rdata=0x2402_0005.
REQ-038 Data write with 3 wait states: d_req=1,d_we=1,d_addr=0x1000,d_wdata=0xDEAD_BEEF, m_ready after 3 cycles -> m_req high 4 cycles, m_* constant, single d_ack, grant_sel=1.
REQ-039 Simultaneous after reset: i_req=d_req=1 held -> fetch served first, then data, then fetch; alternating ack order.
REQ-040 Reset mid-BUSY: d_req read, m_ready=0, assert rst one cycle -> m_req=0, no d_ack, state IDLE, next tie goes to fetch.
REQ-041 Dropped request: i_req pulsed for one grant cycle then low -> transaction completes, i_ack still pulses once; d_ack never asserts.
